// File: rtl/kcpsmx3_inc.sv
// Shared definitions for the kcpsmx3 pipelined core.
// Holds the datapath width, the opcode encoding, the ALU writeback packet
// layout and the interrupt flag-shadow state encoding.
package kcpsmx3_inc;

  localparam int unsigned OPERAND_WIDTH  = 8;
  localparam int unsigned REG_ADDR_WIDTH = 4;

  typedef enum logic [3:0] {
    OpLoad,
    OpAnd,
    OpOr,
    OpXor,
    OpAdd,
    OpAddcy,
    OpSub,
    OpSubcy,
    OpTest,
    OpCompare,
    OpShift,
    OpInput,
    OpFetch,
    OpNop
  } opcode_t;

  typedef struct packed {
    opcode_t                   opcode;
    logic [REG_ADDR_WIDTH-1:0] dest;
    logic [OPERAND_WIDTH-1:0]  result;
    logic                      zero;
    logic                      carry;
    logic                      wr_en;
    logic                      flag_en;
  } wb_pkt_t;

  typedef enum logic [0:0] {
    SHADOW_EMPTY,
    SHADOW_FULL
  } shadow_state_t;

endpackage

// File: rtl/alu_flag_unit.sv
// Architectural Z/C flags plus the single-level interrupt shadow copy.
//
// Ports:
//   clk, reset         core clock, asynchronous active-high reset
//   commit             the held packet retires this cycle
//   flag_en            the retiring packet updates Z/C
//   zero, carry        Z/C values carried by the retiring packet
//   int_save           interrupt entry: copy flags into the shadow
//   int_restore        RETURNI: reload flags from the shadow
//   zero_flag          architectural Z
//   carry_flag         architectural C
//   shadow_err         registered one-cycle pulse on a shadow protocol violation
module alu_flag_unit
  import kcpsmx3_inc::*;
(
  input  logic clk,
  input  logic reset,
  input  logic commit,
  input  logic flag_en,
  input  logic zero,
  input  logic carry,
  input  logic int_save,
  input  logic int_restore,
  output logic zero_flag,
  output logic carry_flag,
  output logic shadow_err
);

  shadow_state_t state_q, state_d;
  logic          z_q, z_d, c_q, c_d;
  logic          sz_q, sz_d, sc_q, sc_d;
  logic          err_q, err_d;
  logic          post_z, post_c;

  always_comb begin
    // Flags as they stand after this cycle's commit; int_save snapshots these.
    post_z  = (commit && flag_en) ? zero  : z_q;
    post_c  = (commit && flag_en) ? carry : c_q;
    z_d     = post_z;
    c_d     = post_c;
    sz_d    = sz_q;
    sc_d    = sc_q;
    state_d = state_q;
    err_d   = 1'b0;
    if (int_restore) begin
      // Restore wins over a same-cycle save; a save alongside it is an error.
      if (state_q == SHADOW_FULL) begin
        z_d     = sz_q;
        c_d     = sc_q;
        state_d = SHADOW_EMPTY;
        err_d   = int_save;
      end else begin
        err_d = 1'b1;
      end
    end else if (int_save) begin
      sz_d    = post_z;
      sc_d    = post_c;
      state_d = SHADOW_FULL;
      err_d   = (state_q == SHADOW_FULL);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SHADOW_EMPTY;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      sz_q    <= 1'b0;
      sc_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      z_q     <= z_d;
      c_q     <= c_d;
      sz_q    <= sz_d;
      sc_q    <= sc_d;
      err_q   <= err_d;
    end
  end

  assign zero_flag  = z_q;
  assign carry_flag = c_q;
  assign shadow_err = err_q;

endmodule

// File: rtl/alu_writeback_stage.sv
// Writeback stage after the ALU: holds one result packet and retires it to
// the register-file write port, updating Z/C and managing the interrupt
// flag shadow.
//
// Optional feature macro: WB_FWD_BYPASS_EN adds fwd_valid/fwd_addr/fwd_data,
// exposing the held entry so operand fetch can bypass the register file.
//
// Ports:
//   clk, reset                   core clock, asynchronous active-high reset
//   in_valid / in_ready          ALU packet handshake
//   in_opcode                    opcode (debug/assertion only)
//   in_dest, in_result           destination register and result
//   in_zero, in_carry            ALU flag outputs
//   in_wr_en, in_flag_en         register write / flag update enables
//   flush                        discard the held packet
//   int_save, int_restore        interrupt entry / RETURNI flag shadowing
//   rf_ready                     register-file write port available
//   rf_we, rf_waddr, rf_wdata    register-file write port
//   zero_flag, carry_flag        architectural flags
//   shadow_err                   shadow protocol violation pulse
module alu_writeback_stage
  import kcpsmx3_inc::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  opcode_t                   in_opcode,
  input  logic [REG_ADDR_WIDTH-1:0] in_dest,
  input  logic [OPERAND_WIDTH-1:0]  in_result,
  input  logic                      in_zero,
  input  logic                      in_carry,
  input  logic                      in_wr_en,
  input  logic                      in_flag_en,
  input  logic                      flush,
  input  logic                      int_save,
  input  logic                      int_restore,
  input  logic                      rf_ready,
  output logic                      rf_we,
  output logic [REG_ADDR_WIDTH-1:0] rf_waddr,
  output logic [OPERAND_WIDTH-1:0]  rf_wdata,
  output logic                      zero_flag,
  output logic                      carry_flag,
`ifdef WB_FWD_BYPASS_EN
  output logic                      fwd_valid,
  output logic [REG_ADDR_WIDTH-1:0] fwd_addr,
  output logic [OPERAND_WIDTH-1:0]  fwd_data,
`endif
  output logic                      shadow_err
);

  wb_pkt_t hold_q, hold_d;
  logic    held_valid_q, held_valid_d;
  logic    capture, commit;

  always_comb begin
    in_ready     = !held_valid_q || (rf_ready && !flush);
    commit       = held_valid_q && rf_ready && !flush;
    // A packet offered during a flush is dropped even if the entry is free.
    capture      = in_valid && in_ready && !flush;
    hold_d       = hold_q;
    held_valid_d = held_valid_q;
    if (flush) begin
      held_valid_d = 1'b0;
    end else if (capture) begin
      held_valid_d   = 1'b1;
      hold_d.opcode  = in_opcode;
      hold_d.dest    = in_dest;
      hold_d.result  = in_result;
      hold_d.zero    = in_zero;
      hold_d.carry   = in_carry;
      hold_d.wr_en   = in_wr_en;
      hold_d.flag_en = in_flag_en;
    end else if (commit) begin
      held_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      held_valid_q <= 1'b0;
      hold_q       <= '0;
    end else begin
      held_valid_q <= held_valid_d;
      hold_q       <= hold_d;
    end
  end

  assign rf_we    = commit && hold_q.wr_en;
  assign rf_waddr = hold_q.dest;
  assign rf_wdata = hold_q.result;

`ifdef WB_FWD_BYPASS_EN
  assign fwd_valid = held_valid_q && hold_q.wr_en && !flush;
  assign fwd_addr  = hold_q.dest;
  assign fwd_data  = hold_q.result;
`endif

  alu_flag_unit u_flag_unit (
    .clk         (clk),
    .reset       (reset),
    .commit      (commit),
    .flag_en     (hold_q.flag_en),
    .zero        (hold_q.zero),
    .carry       (hold_q.carry),
    .int_save    (int_save),
    .int_restore (int_restore),
    .zero_flag   (zero_flag),
    .carry_flag  (carry_flag),
    .shadow_err  (shadow_err)
  );

  // A held entry must always carry a well-defined opcode.
  held_opcode_known: assert property (
    @(posedge clk) disable iff (reset) held_valid_q |-> !$isunknown(hold_q.opcode)
  );

endmodule

// File: tb/tb_alu_writeback_stage.sv
module tb_alu_writeback_stage;
  import kcpsmx3_inc::*;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      in_valid;
  logic                      in_ready;
  opcode_t                   in_opcode;
  logic [REG_ADDR_WIDTH-1:0] in_dest;
  logic [OPERAND_WIDTH-1:0]  in_result;
  logic                      in_zero, in_carry, in_wr_en, in_flag_en;
  logic                      flush, int_save, int_restore, rf_ready;
  logic                      rf_we;
  logic [REG_ADDR_WIDTH-1:0] rf_waddr;
  logic [OPERAND_WIDTH-1:0]  rf_wdata;
  logic                      zero_flag, carry_flag, shadow_err;
`ifdef WB_FWD_BYPASS_EN
  logic                      fwd_valid;
  logic [REG_ADDR_WIDTH-1:0] fwd_addr;
  logic [OPERAND_WIDTH-1:0]  fwd_data;
`endif

  alu_writeback_stage dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_opcode   (in_opcode),
    .in_dest     (in_dest),
    .in_result   (in_result),
    .in_zero     (in_zero),
    .in_carry    (in_carry),
    .in_wr_en    (in_wr_en),
    .in_flag_en  (in_flag_en),
    .flush       (flush),
    .int_save    (int_save),
    .int_restore (int_restore),
    .rf_ready    (rf_ready),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .zero_flag   (zero_flag),
    .carry_flag  (carry_flag),
`ifdef WB_FWD_BYPASS_EN
    .fwd_valid   (fwd_valid),
    .fwd_addr    (fwd_addr),
    .fwd_data    (fwd_data),
`endif
    .shadow_err  (shadow_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One row = one cycle: inputs driven, then outputs expected before the edge.
  typedef struct {
    logic v; logic [3:0] d; logic [7:0] r; logic z, c, we, fe;
    logic fl, sv, rs, rr;
    logic e_rdy, e_we; logic [3:0] e_a; logic [7:0] e_d; logic e_z, e_c, e_err;
  } vec_t;

  function automatic vec_t mk(logic v, logic [3:0] d, logic [7:0] r, logic z, logic c,
                              logic we, logic fe, logic fl, logic sv, logic rs, logic rr,
                              logic e_rdy, logic e_we, logic [3:0] e_a, logic [7:0] e_d,
                              logic e_z, logic e_c, logic e_err);
    vec_t t;
    t.v = v; t.d = d; t.r = r; t.z = z; t.c = c; t.we = we; t.fe = fe;
    t.fl = fl; t.sv = sv; t.rs = rs; t.rr = rr;
    t.e_rdy = e_rdy; t.e_we = e_we; t.e_a = e_a; t.e_d = e_d;
    t.e_z = e_z; t.e_c = e_c; t.e_err = e_err;
    return t;
  endfunction

  task automatic drive(logic v, logic [3:0] d, logic [7:0] r, logic z, logic c, logic we,
                       logic fe, logic fl, logic sv, logic rs, logic rr);
    in_valid = v; in_dest = d; in_result = r; in_zero = z; in_carry = c;
    in_wr_en = we; in_flag_en = fe; flush = fl; int_save = sv; int_restore = rs;
    rf_ready = rr;
  endtask

  // Reference model state, in terms of the architectural behaviour.
  logic       m_hv, m_z, m_c, m_sz, m_sc, m_full, m_err;
  logic [3:0] m_dest;
  logic [7:0] m_res;
  logic       m_pz, m_pc, m_pwe, m_pfe;

  vec_t tbl[$];

  initial begin
    reset = 1'b1;
    in_opcode = OpAdd;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    repeat (2) @(negedge clk);
    #1;
    chk("reset.in_ready", int'(in_ready), 1);
    chk("reset.rf_we", int'(rf_we), 0);
    chk("reset.rf_waddr", int'(rf_waddr), 0);
    chk("reset.rf_wdata", int'(rf_wdata), 0);
    chk("reset.zero_flag", int'(zero_flag), 0);
    chk("reset.carry_flag", int'(carry_flag), 0);
    chk("reset.shadow_err", int'(shadow_err), 0);
    reset = 1'b0;

    //          v  d   res z  c  we fe fl sv rs rr | rdy we a  data Z  C  err
    tbl.push_back(mk(1, 3, 8'hA5, 0, 1, 1, 1, 0, 0, 0, 1, 1, 0, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 3, 8'hA5, 0, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 8'h00, 0, 1, 0));
    tbl.push_back(mk(1, 7, 8'h10, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 8'h00, 0, 1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 1, 0));
    tbl.push_back(mk(1, 9, 8'h55, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 7, 8'h10, 0, 1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(1, 2, 8'hFF, 1, 0, 1, 1, 0, 0, 0, 1, 1, 0, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(1, 1, 8'h00, 1, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 8'h00, 1, 0, 0));
    tbl.push_back(mk(1, 4, 8'h33, 0, 1, 1, 1, 0, 0, 0, 1, 1, 0, 0, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 4, 8'h33, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 8'h00, 0, 1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 8'h00, 1, 0, 1));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 8'h00, 1, 0, 0));
    tbl.push_back(mk(1, 5, 8'h77, 1, 1, 0, 1, 0, 0, 0, 1, 1, 0, 0, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 8'h00, 1, 1, 0));
    tbl.push_back(mk(1, 6, 8'h0C, 0, 0, 1, 1, 0, 0, 0, 1, 1, 0, 0, 8'h00, 1, 1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 6, 8'h0C, 1, 1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 8'h00, 1, 1, 0));
    tbl.push_back(mk(1, 8, 8'h81, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 8'h00, 1, 1, 0));
    tbl.push_back(mk(1, 9, 8'h92, 0, 0, 1, 0, 0, 0, 0, 1, 1, 1, 8, 8'h81, 1, 1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 9, 8'h92, 1, 1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 8'h00, 1, 1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 8'h00, 1, 1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 8'h00, 1, 1, 1));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 8'h00, 1, 1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 8'h00, 1, 1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 8'h00, 1, 1, 1));
    tbl.push_back(mk(1, 11, 8'hEE, 0, 0, 1, 1, 1, 0, 0, 1, 1, 0, 0, 8'h00, 1, 1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 8'h00, 1, 1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 8'h00, 1, 1, 0));

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].v, tbl[i].d, tbl[i].r, tbl[i].z, tbl[i].c, tbl[i].we, tbl[i].fe,
            tbl[i].fl, tbl[i].sv, tbl[i].rs, tbl[i].rr);
      #1;
      chk($sformatf("row%0d.in_ready", i), int'(in_ready), int'(tbl[i].e_rdy));
      chk($sformatf("row%0d.rf_we", i), int'(rf_we), int'(tbl[i].e_we));
      if (tbl[i].e_we) begin
        chk($sformatf("row%0d.rf_waddr", i), int'(rf_waddr), int'(tbl[i].e_a));
        chk($sformatf("row%0d.rf_wdata", i), int'(rf_wdata), int'(tbl[i].e_d));
      end
      chk($sformatf("row%0d.zero_flag", i), int'(zero_flag), int'(tbl[i].e_z));
      chk($sformatf("row%0d.carry_flag", i), int'(carry_flag), int'(tbl[i].e_c));
      chk($sformatf("row%0d.shadow_err", i), int'(shadow_err), int'(tbl[i].e_err));
    end

    // Reset while a packet is held: flags are 1/1 here, so clearing is visible.
    @(negedge clk);
    drive(1, 10, 8'hC3, 1, 1, 1, 1, 0, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rst_mid.held_no_we", int'(rf_we), 0);
    chk("rst_mid.held_waddr", int'(rf_waddr), 10);
    #1;
    reset = 1'b1;
    rf_ready = 1'b1;
    #1;
    chk("rst_mid.rf_we", int'(rf_we), 0);
    chk("rst_mid.rf_waddr", int'(rf_waddr), 0);
    chk("rst_mid.rf_wdata", int'(rf_wdata), 0);
    chk("rst_mid.zero_flag", int'(zero_flag), 0);
    chk("rst_mid.carry_flag", int'(carry_flag), 0);
    chk("rst_mid.shadow_err", int'(shadow_err), 0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk($sformatf("rst_after%0d.rf_we", k), int'(rf_we), 0);
      @(negedge clk);
    end

    // Randomized phase against the reference model (state equals post-reset).
    m_hv = 0; m_z = 0; m_c = 0; m_sz = 0; m_sc = 0; m_full = 0; m_err = 0;
    m_dest = 0; m_res = 0; m_pz = 0; m_pc = 0; m_pwe = 0; m_pfe = 0;
    for (int n = 0; n < 2000; n++) begin
      logic e_rdy, commit, accept, nz, nc, nerr;
      @(negedge clk);
      drive($urandom_range(0, 9) < 6, 4'($urandom), 8'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 9) == 0,
            $urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0,
            $urandom_range(0, 9) < 7);
      in_opcode = opcode_t'($urandom_range(0, 13));
      #1;
      e_rdy  = !m_hv || (rf_ready && !flush);
      commit = m_hv && rf_ready && !flush;
      chk($sformatf("rnd%0d.in_ready", n), int'(in_ready), int'(e_rdy));
      chk($sformatf("rnd%0d.rf_we", n), int'(rf_we), int'(commit && m_pwe));
      chk($sformatf("rnd%0d.rf_waddr", n), int'(rf_waddr), int'(m_dest));
      chk($sformatf("rnd%0d.rf_wdata", n), int'(rf_wdata), int'(m_res));
      chk($sformatf("rnd%0d.zero_flag", n), int'(zero_flag), int'(m_z));
      chk($sformatf("rnd%0d.carry_flag", n), int'(carry_flag), int'(m_c));
      chk($sformatf("rnd%0d.shadow_err", n), int'(shadow_err), int'(m_err));
`ifdef WB_FWD_BYPASS_EN
      chk($sformatf("rnd%0d.fwd_valid", n), int'(fwd_valid), int'(m_hv && m_pwe && !flush));
      chk($sformatf("rnd%0d.fwd_data", n), int'(fwd_data), int'(m_res));
`endif
      // Advance the model by one clock edge.
      accept = in_valid && e_rdy && !flush;
      nz = (commit && m_pfe) ? m_pz : m_z;
      nc = (commit && m_pfe) ? m_pc : m_c;
      nerr = 0;
      if (int_restore) begin
        if (m_full) begin
          nz = m_sz; nc = m_sc; m_full = 0; nerr = int_save;
        end else begin
          nerr = 1;
        end
      end else if (int_save) begin
        nerr = m_full;
        m_sz = nz; m_sc = nc; m_full = 1;
      end
      m_z = nz; m_c = nc; m_err = nerr;
      if (accept) begin
        m_hv = 1; m_dest = in_dest; m_res = in_result; m_pz = in_zero; m_pc = in_carry;
        m_pwe = in_wr_en; m_pfe = in_flag_en;
      end else if (commit || flush) begin
        m_hv = 0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_writeback_stage.md
Name: alu_writeback_stage

Overview:
- Pipeline stage directly downstream of the ALU in the pipelined PicoBlaze (kcpsmx3) core.
- Captures the ALU result packet (result, zero_out, carry_out, destination register, write/flag-update controls) and commits it to the register-file write port.
- Owns the architectural Z/C flags and the interrupt shadow copy of those flags used by interrupt entry and RETURNI.
- Single-entry, valid/ready handshaked stage with flush support.

Parameters:
- OPERAND_WIDTH, 8, data width; taken from the kcpsmx3_inc package.
- REG_ADDR_WIDTH, 4, register-file address width (16 registers).

Ports:
- clk  input  1  core clock
- reset  input  1  asynchronous reset, active-high
- in_valid  input  1  ALU packet valid
- in_ready  output  1  stage can accept a packet this cycle
- in_opcode  input  opcode_t  opcode of the instruction; used only by debug/assertions
- in_dest  input  REG_ADDR_WIDTH  destination register
- in_result  input  OPERAND_WIDTH  ALU result
- in_zero  input  1  ALU zero_out
- in_carry  input  1  ALU carry_out
- in_wr_en  input  1  instruction writes a register
- in_flag_en  input  1  instruction updates Z/C
- flush  input  1  discard the held packet (branch/interrupt redirect)
- int_save  input  1  interrupt acknowledged; copy flags to shadow
- int_restore  input  1  RETURNI; restore flags from shadow
- rf_ready  input  1  register-file write port available
- rf_we  output  1  register-file write strobe
- rf_waddr  output  REG_ADDR_WIDTH  write address
- rf_wdata  output  OPERAND_WIDTH  write data
- zero_flag  output  1  architectural Z
- carry_flag  output  1  architectural C
- shadow_err  output  1  one-cycle pulse on a shadow protocol violation

Behaviour:
- Reset (async): held_valid=0; zero_flag=0; carry_flag=0; shadow Z/C=0; shadow state=EMPTY; rf_we=0; rf_waddr=0; rf_wdata=0; shadow_err=0. in_ready=1 after reset.
- Capture: when in_valid & in_ready, the packet is registered into the holding entry and held_valid=1.
- in_ready = !held_valid | (rf_ready & !flush). This allows back-to-back throughput of 1 packet/cycle.
- Commit: occurs on a cycle with held_valid & rf_ready & !flush.
  - rf_we = held_valid & held_wr_en & rf_ready & !flush (combinational from registered state).
  - rf_waddr and rf_wdata are driven from the holding entry.
  - Latency from ALU capture edge to rf_we is 1 cycle when rf_ready=1.
  - On the commit edge, if held_flag_en: zero_flag<=held_zero and carry_flag<=held_carry. Otherwise flags are unchanged.
  - held_valid clears unless a new packet is captured in the same cycle.
- rf_ready=0: the packet is held, with outputs stable, until rf_ready=1. No flag update occurs while held.
- flush: held_valid<=0, no commit, no flag update. in_valid is ignored that cycle (in_ready=0 when held_valid=1; if held_valid=0, a packet offered with flush is dropped).
- Packets with wr_en=0 and flag_en=0 still pass through the stage and consume 1 cycle.
- Shadow state machine, EMPTY / FULL:
  - int_save in EMPTY: shadow<=flags as they will be after any same-cycle commit; state->FULL.
  - int_save in FULL: shadow is overwritten (nesting unsupported); shadow_err pulses.
  - int_restore in FULL: flags<=shadow; state->EMPTY. Restore overrides any same-cycle commit flag update; the register write still commits.
  - int_restore in EMPTY: flags unchanged; shadow_err pulses.
  - int_save and int_restore in the same cycle: restore is applied and save is ignored; shadow_err pulses.
- Reset mid-operation: the held packet is discarded and no rf_we is produced.

Optional Feature:
- Macro WB_FWD_BYPASS_EN.
- When defined, adds outputs fwd_valid (1), fwd_addr (REG_ADDR_WIDTH) and fwd_data (OPERAND_WIDTH). These expose the holding entry: fwd_valid = held_valid & held_wr_en & !flush. They let the decode/operand stage bypass results not yet written to the register file. All three reset to 0.
- When undefined, these ports are absent and behaviour is otherwise identical.

Decomposition:
- Package kcpsmx3_inc (existing) holds OPERAND_WIDTH and opcode_t.
- Add to that package: REG_ADDR_WIDTH, struct wb_pkt_t {dest, result, zero, carry, wr_en, flag_en, opcode}, and enum shadow_state_t {SHADOW_EMPTY, SHADOW_FULL}.
- One sub-module, alu_flag_unit, owns the Z/C flags, the shadow registers and the shadow FSM. Its inputs are commit, flag_en, zero, carry, int_save and int_restore.

Test Plan:
- Captured packet dest=3, result=8'hA5, wr_en=1, flag_en=1, z=0, c=1, with rf_ready=1: next cycle rf_we=1, rf_waddr=3, rf_wdata=A5; after the commit edge Z=0, C=1.
- rf_ready=0 for 3 cycles while a packet dest=7, result=8'h10 is held: in_ready=0, rf_we=0, flags unchanged. rf_ready rises -> single write of 8'h10 to r7.
- Flush on the cycle the held packet would commit (result=8'hFF, flag_en=1, z=1): no rf_we, Z stays 0.
- Flags Z=1, C=0; int_save; then packet with flag_en=1 sets Z=0, C=1; then int_restore -> Z=1, C=0, state EMPTY. A second int_restore pulses shadow_err and leaves flags unchanged.
- Same-cycle commit (flag_en=1, z=0, c=0) and int_restore with shadow Z=1, C=1 -> flags Z=1, C=1 and the register write still occurs.
- Reset asserted while a packet is held with rf_ready=0: all outputs 0 immediately; after reset deasserts, rf_ready=1 produces no write.
